// File: rtl/pipepc_ras.sv
// Program-counter register with stall-aware redirect capture and a circular
// return-address stack that predicts the target of returns.
module pipepc_ras #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0008),
    parameter int               INC       = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [WIDTH-1:0] npc,
    input  logic             redir,
    input  logic [WIDTH-1:0] redir_pc,
    input  logic             exc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic             redir_pend,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam int               PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pendPc_q, pendPc_d;
    logic [PTR_W-1:0] topIdx_q, topIdx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             wrEn;
    logic [PTR_W-1:0] wrIdx;
    logic [WIDTH-1:0] wrData;
    logic [WIDTH-1:0] pcInc;
    logic             stackEmpty;
    logic             doPop;
    logic [WIDTH-1:0] topVal;

    assign pcInc      = pc_q + INC_W;
    assign stackEmpty = (cnt_q == '0);
    assign topVal     = stackEmpty ? '0 : ras_q[topIdx_q];
    assign doPop      = ret && !stackEmpty;

    // topIdx_q always names the newest entry; a push advances it first, so a
    // push while full lands on the oldest slot and overwrites it.
    always_comb begin
        pc_d     = pc_q;
        pend_d   = pend_q;
        pendPc_d = pendPc_q;
        topIdx_d = topIdx_q;
        cnt_d    = cnt_q;
        wrEn     = 1'b0;
        wrIdx    = topIdx_q;
        wrData   = pcInc;

        if (exc) begin
            pc_d   = EXC_VEC;
            pend_d = 1'b0;
        end else if (redir) begin
            if (we) begin
                pc_d   = redir_pc;
                pend_d = 1'b0;
            end else begin
                pend_d   = 1'b1;
                pendPc_d = redir_pc;
            end
        end else if (we) begin
            if (pend_q) begin
                pc_d   = pendPc_q;
                pend_d = 1'b0;
            end else begin
                pc_d = doPop ? topVal : npc;
                if (call && doPop) begin
                    wrEn  = 1'b1;
                    wrIdx = topIdx_q;
                end else if (call) begin
                    wrEn     = 1'b1;
                    wrIdx    = topIdx_q + PTR_W'(1);
                    topIdx_d = topIdx_q + PTR_W'(1);
                    if (cnt_q != CNT_FULL) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (doPop) begin
                    topIdx_d = topIdx_q - PTR_W'(1);
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q     <= RESET_VEC;
            pend_q   <= 1'b0;
            pendPc_q <= '0;
            topIdx_q <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            pendPc_q <= pendPc_d;
            topIdx_q <= topIdx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (wrEn) begin
            ras_q[wrIdx] <= wrData;
        end
    end

    assign pc         = pc_q;
    assign redir_pend = pend_q;
    assign ras_top    = topVal;
    assign ras_empty  = stackEmpty;
    assign ras_full   = (cnt_q == CNT_FULL);

endmodule

// File: doc/pipepc_ras.md
PIPEPC_RAS -- requirements
Module: pipepc_ras

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC and address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h00000000, meaning PC value loaded on reset.
REQ-003 SHALL have parameter EXC_VEC, default 32'h00000008, meaning PC value loaded on exception.
REQ-004 SHALL have parameter INC, default 4, meaning sequential increment used for return addresses.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, >=2).
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-007 SHALL have port clr, input, 1 bit, meaning the asynchronous, active-high reset.
REQ-008 SHALL have port we, input, 1 bit, meaning advance enable (0 = pipeline stall).
REQ-009 SHALL have port npc, input, WIDTH bits, meaning the default next PC from fetch/decode selection.
REQ-010 SHALL have port redir, input, 1 bit, meaning a resolved branch/jump redirect request.
REQ-011 SHALL have port redir_pc, input, WIDTH bits, meaning the redirect target.
REQ-012 SHALL have port exc, input, 1 bit, meaning an exception request.
REQ-013 SHALL have port call, input, 1 bit, meaning push return address (pc+INC).
REQ-014 SHALL have port ret, input, 1 bit, meaning next PC is taken from the stack top.
REQ-015 SHALL have port pc, output, WIDTH bits, meaning the registered program counter.
REQ-016 SHALL have port redir_pend, output, 1 bit, meaning a redirect captured during stall awaits application.
REQ-017 SHALL have port ras_top, output, WIDTH bits, meaning the current stack-top entry (0 when empty).
REQ-018 SHALL have port ras_empty, output, 1 bit, meaning the stack holds no entries.
REQ-019 SHALL have port ras_full, output, 1 bit, meaning the stack holds RAS_DEPTH entries.

Function
REQ-020 SHALL resolve each edge by fixed priority: exc > redir > pending redirect > ret > npc.
REQ-021 SHALL, on exc=1, load pc<=EXC_VEC regardless of we, clear pending, and ignore call/ret.
REQ-022 SHALL, on redir=1 with we=1 and exc=0, load pc<=redir_pc, clear pending, and ignore call/ret.
REQ-023 SHALL, on redir=1 with we=0 and exc=0, hold pc, set pending and store redir_pc; a later redir during the stall overwrites the stored target.
REQ-024 SHALL, on we=1 with pending set and no exc/redir, load pc<=stored target, clear pending, and ignore call/ret.
REQ-025 SHALL, on we=0 with no exc/redir, hold pc, pending state and the stack unchanged.
REQ-026 SHALL, in the normal case (we=1, no exc/redir/pending, ret=0), load pc<=npc.
REQ-027 SHALL, on ret=1 in the normal case with the stack non-empty, load pc<=ras_top and pop one entry.
REQ-028 SHALL, on ret=1 with the stack empty, load pc<=npc and leave the stack unchanged.
REQ-029 SHALL, on call=1 in the normal case, push (pc+INC) mod 2^WIDTH, using the current pc.
REQ-030 SHALL, on a push while full, overwrite the oldest entry circularly, with the count saturated at RAS_DEPTH.
REQ-031 SHALL, on call and ret in the same normal-case edge, use the old top for pc and replace the top with pc+INC, leaving the count unchanged; on an empty stack, pc<=npc and a plain push occurs.
REQ-032 SHALL truncate all PC arithmetic to WIDTH bits (wrap-around, no carry out).
REQ-033 SHALL make ras_top, ras_empty and ras_full combinational from registered stack state, with a single-cycle update latency.

Reset
REQ-034 SHALL, while clr=1, immediately force pc=RESET_VEC, redir_pend=0, stack count=0, all entries=0, ras_empty=1, ras_full=0.
REQ-035 SHALL, on clr asserted mid-stall with pending set, discard the pending redirect; the first edge after release applies the normal priority rules.

Verification
REQ-036 SHALL cover reset then we=1, npc=0x4,0x8 -> pc=0x0, then 0x4, then 0x8; ras_empty=1 throughout.
REQ-037 SHALL cover pc=0x100, we=0, redir=1 with redir_pc=0x200 for one cycle, stall held 3 cycles -> pc=0x100 and redir_pend=1; at the we=1 edge -> pc=0x200 and redir_pend=0.
REQ-038 SHALL cover exc=1 with redir=1 and we=0 at pc=0x40 -> pc=0x8 and redir_pend=0.
REQ-039 SHALL cover RAS_DEPTH=4 with five calls at pc=0x10,0x20,0x30,0x40,0x50 then five rets -> pc sequence 0x54,0x44,0x34,0x24, and on the fifth ret pc=npc with ras_empty=1.
REQ-040 SHALL cover pc=0xFFFFFFFC with call=1 -> ras_top=0x00000000.
REQ-041 SHALL cover call and ret together with top=0x80 at pc=0x300 -> pc=0x80, ras_top=0x304, count unchanged.
